// File: rtl/secand_pkg.sv
// -----------------------------------------------------------------------------
// secand_pkg
// Shared constants and types for the SecAND arbiter slice.
//   K_WIDTH    : bits per Boolean share
//   N_SHARES   : number of Boolean shares
//   RANDNUM    : randomness words consumed per masked AND
//   MASKWIDTH  : width of one masked operand (all shares concatenated)
//   req_id_e   : requester identity carried through the tag pipeline
//   tag_t      : one tag pipeline stage {valid, requester id}
// -----------------------------------------------------------------------------
package secand_pkg;

    localparam int K_WIDTH   = 32;
    localparam int N_SHARES  = 8;
    localparam int RANDNUM   = N_SHARES * (N_SHARES - 1);
    localparam int MASKWIDTH = K_WIDTH * N_SHARES;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    vld;
        req_id_e id;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{vld: 1'b0, id: REQ_A};

    function automatic req_id_e other_req(input req_id_e r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/secand_tag_pipe.sv
// -----------------------------------------------------------------------------
// secand_tag_pipe
// LAT-deep shift register of {valid, requester id} tags. One tag enters at the
// head every cycle; the tail lines up with the gadget result of the operation
// issued LAT cycles earlier.
//   clk  : clock
//   rst  : synchronous active-high reset, clears every stage
//   head : tag written into the first stage at each clock edge
//   tail : tag held in the last stage
// -----------------------------------------------------------------------------
module secand_tag_pipe
    import secand_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t head,
    output tag_t tail
);

    tag_t [LAT-1:0] stage;

    if (LAT == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                stage <= '0;
            end else begin
                stage <= head;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (rst) begin
                stage <= '0;
            end else begin
                stage <= {stage[LAT-2:0], head};
            end
        end
    end

    assign tail = stage[LAT-1];

endmodule

// File: rtl/secand_arb.sv
// -----------------------------------------------------------------------------
// secand_arb
// Round-robin arbiter/sequencer sharing one SecAND masked-AND gadget between
// requesters A and B. Grants one operation per cycle when randomness is
// available, tracks in-flight operations with a tag pipeline and routes each
// gadget result back to its issuer.
//   clk, rst              : clock, synchronous active-high reset
//   a_vld/a_rdy/a_x/a_y   : requester A operand handshake
//   a_ovld/a_z            : requester A result (z holds between results)
//   b_*                   : same for requester B
//   rnd_vld/rnd_rdy/rnd_in: RNG word handshake
//   g_ena/g_dvld/g_x/g_y/g_rnd : gadget inputs (zeroed when idle)
//   g_z/g_ovld            : gadget result
//   err                   : sticky protocol error (result/tag disagreement)
// -----------------------------------------------------------------------------
module secand_arb
    import secand_pkg::*;
#(
    parameter int K_WIDTH  = secand_pkg::K_WIDTH,
    parameter int N_SHARES = secand_pkg::N_SHARES,
    parameter int LAT      = 1,
    localparam int RANDNUM   = N_SHARES * (N_SHARES - 1),
    localparam int MASKWIDTH = K_WIDTH * N_SHARES
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        a_vld,
    output logic                        a_rdy,
    input  logic [MASKWIDTH-1:0]        a_x,
    input  logic [MASKWIDTH-1:0]        a_y,
    output logic                        a_ovld,
    output logic [MASKWIDTH-1:0]        a_z,

    input  logic                        b_vld,
    output logic                        b_rdy,
    input  logic [MASKWIDTH-1:0]        b_x,
    input  logic [MASKWIDTH-1:0]        b_y,
    output logic                        b_ovld,
    output logic [MASKWIDTH-1:0]        b_z,

    input  logic                        rnd_vld,
    output logic                        rnd_rdy,
    input  logic [K_WIDTH*RANDNUM-1:0]  rnd_in,

    output logic                        g_ena,
    output logic                        g_dvld,
    output logic [MASKWIDTH-1:0]        g_x,
    output logic [MASKWIDTH-1:0]        g_y,
    output logic [K_WIDTH*RANDNUM-1:0]  g_rnd,
    input  logic [MASKWIDTH-1:0]        g_z,
    input  logic                        g_ovld,

    output logic                        err
);

    req_id_e              fav;
    logic                 grant;
    req_id_e              win;
    tag_t                 head;
    tag_t                 tail;
    logic                 resp_ok;
    logic                 err_q;
    logic [MASKWIDTH-1:0] a_z_q;
    logic [MASKWIDTH-1:0] b_z_q;

    // Grant decision: a lone requester always wins, contention goes to fav.
    always_comb begin
        grant = 1'b0;
        win   = fav;
        if (!rst && rnd_vld && (a_vld || b_vld)) begin
            grant = 1'b1;
            if (a_vld && b_vld) begin
                win = fav;
            end else if (a_vld) begin
                win = REQ_A;
            end else begin
                win = REQ_B;
            end
        end
    end

    assign a_rdy   = grant && (win == REQ_A);
    assign b_rdy   = grant && (win == REQ_B);
    assign rnd_rdy = grant;
    assign g_dvld  = grant;
    assign g_ena   = ~rst;

    // Masked data is forced to zero whenever the bus is idle.
    assign g_x   = !grant ? '0 : ((win == REQ_A) ? a_x : b_x);
    assign g_y   = !grant ? '0 : ((win == REQ_A) ? a_y : b_y);
    assign g_rnd = grant ? rnd_in : '0;

    assign head = grant ? '{vld: 1'b1, id: win} : TAG_EMPTY;

    secand_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .head (head),
        .tail (tail)
    );

    // A result is only forwarded when the gadget and the tag pipe agree.
    assign resp_ok = !rst && g_ovld && tail.vld;
    assign a_ovld  = resp_ok && (tail.id == REQ_A);
    assign b_ovld  = resp_ok && (tail.id == REQ_B);

    // z follows the gadget in the response cycle, otherwise holds its last value.
    assign a_z = a_ovld ? g_z : a_z_q;
    assign b_z = b_ovld ? g_z : b_z_q;
    assign err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fav   <= REQ_A;
            err_q <= 1'b0;
            a_z_q <= '0;
            b_z_q <= '0;
        end else begin
            if (grant) begin
                fav <= other_req(win);
            end
            if (a_ovld) begin
                a_z_q <= g_z;
            end
            if (b_ovld) begin
                b_z_q <= g_z;
            end
            if (g_ovld != tail.vld) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_secand_arb.sv
module tb_secand_arb;
    import secand_pkg::*;

    localparam int MW = K_WIDTH * N_SHARES;
    localparam int RW = K_WIDTH * RANDNUM;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_vld, b_vld, rnd_vld;
    logic [MW-1:0] a_x, a_y, b_x, b_y;
    logic [RW-1:0] rnd_in;

    // Index 0: DUT with LAT=1, index 1: DUT with LAT=3.
    logic          a_rdy [2];
    logic          b_rdy [2];
    logic          rnd_rdy [2];
    logic          a_ovld [2];
    logic          b_ovld [2];
    logic          g_ena [2];
    logic          g_dvld [2];
    logic          g_ovld [2];
    logic          err [2];
    logic          spur [2];
    logic [MW-1:0] a_z [2];
    logic [MW-1:0] b_z [2];
    logic [MW-1:0] g_x [2];
    logic [MW-1:0] g_y [2];
    logic [MW-1:0] g_z [2];
    logic [RW-1:0] g_rnd [2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        secand_arb #(
            .K_WIDTH  (K_WIDTH),
            .N_SHARES (N_SHARES),
            .LAT      ((d == 0) ? 1 : 3)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .a_vld   (a_vld),
            .a_rdy   (a_rdy[d]),
            .a_x     (a_x),
            .a_y     (a_y),
            .a_ovld  (a_ovld[d]),
            .a_z     (a_z[d]),
            .b_vld   (b_vld),
            .b_rdy   (b_rdy[d]),
            .b_x     (b_x),
            .b_y     (b_y),
            .b_ovld  (b_ovld[d]),
            .b_z     (b_z[d]),
            .rnd_vld (rnd_vld),
            .rnd_rdy (rnd_rdy[d]),
            .rnd_in  (rnd_in),
            .g_ena   (g_ena[d]),
            .g_dvld  (g_dvld[d]),
            .g_x     (g_x[d]),
            .g_y     (g_y[d]),
            .g_rnd   (g_rnd[d]),
            .g_z     (g_z[d]),
            .g_ovld  (g_ovld[d]),
            .err     (err[d])
        );
    end

    function automatic logic [K_WIDTH-1:0] unmask(input logic [MW-1:0] v);
        logic [K_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < N_SHARES; i++) r ^= v[i*K_WIDTH +: K_WIDTH];
        return r;
    endfunction

    function automatic logic [MW-1:0] mask(input logic [K_WIDTH-1:0] v);
        logic [MW-1:0]      r;
        logic [K_WIDTH-1:0] acc;
        acc = v;
        r   = '0;
        for (int i = 1; i < N_SHARES; i++) begin
            r[i*K_WIDTH +: K_WIDTH] = $urandom;
            acc ^= r[i*K_WIDTH +: K_WIDTH];
        end
        r[K_WIDTH-1:0] = acc;
        return r;
    endfunction

    // Behavioural gadget stand-in: unmasked AND re-shared with fresh masks,
    // delivered after the DUT's latency; held in reset together with the DUT.
    logic          pv [2][8];
    logic [MW-1:0] pz [2][8];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) pv[d][i] <= 1'b0;
            end else begin
                for (int i = 7; i > 0; i--) begin
                    pv[d][i] <= pv[d][i-1];
                    pz[d][i] <= pz[d][i-1];
                end
                pv[d][0] <= g_dvld[d];
                pz[d][0] <= mask(unmask(g_x[d]) & unmask(g_y[d]));
            end
        end
    end

    always_comb begin
        g_ovld[0] = pv[0][0] | spur[0];
        g_z[0]    = pz[0][0];
        g_ovld[1] = pv[1][2] | spur[1];
        g_z[1]    = pz[1][2];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int d, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, d, got, exp);
        end
    endtask

    task automatic chkw(input string name, input int d, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, d, got, exp);
        end
    endtask

    // Reference model: expected responses parked in a slot calendar keyed by
    // the cycle in which they are due.
    int                 cyc = 0;
    logic               ptr [2];
    logic               err_exp [2];
    logic               slot_v [2][16];
    logic               slot_id [2][16];
    logic [K_WIDTH-1:0] slot_val [2][16];
    logic [K_WIDTH-1:0] last_z [2][2];
    logic               model_grant;
    logic               model_win;

    task automatic model(input int d);
        int                 lat;
        int                 s;
        int                 t;
        logic               gnt;
        logic               w;
        logic               id;
        logic               err_next;
        logic [MW-1:0]      wx;
        logic [MW-1:0]      wy;
        logic [RW-1:0]      wr;
        lat = (d == 0) ? 1 : 3;
        s   = cyc % 16;
        if (rst) begin
            chk("rst_a_rdy", d, a_rdy[d], 0);
            chk("rst_b_rdy", d, b_rdy[d], 0);
            chk("rst_g_dvld", d, g_dvld[d], 0);
            chk("rst_a_ovld", d, a_ovld[d], 0);
            chk("rst_b_ovld", d, b_ovld[d], 0);
            ptr[d]     = 1'b0;
            err_exp[d] = 1'b0;
            for (int i = 0; i < 16; i++) slot_v[d][i] = 1'b0;
            last_z[d][0] = '0;
            last_z[d][1] = '0;
            if (d == 0) model_grant = 1'b0;
            return;
        end
        chk("err", d, err[d], err_exp[d]);
        chk("g_ena", d, g_ena[d], 1);
        gnt = rnd_vld && (a_vld || b_vld);
        w   = (a_vld && b_vld) ? ptr[d] : b_vld;
        chk("a_rdy", d, a_rdy[d], gnt && !w);
        chk("b_rdy", d, b_rdy[d], gnt && w);
        chk("rnd_rdy", d, rnd_rdy[d], gnt);
        chk("g_dvld", d, g_dvld[d], gnt);
        wx = gnt ? (w ? b_x : a_x) : '0;
        wy = gnt ? (w ? b_y : a_y) : '0;
        wr = gnt ? rnd_in : '0;
        chkw("g_x", d, g_x[d], wx);
        chkw("g_y", d, g_y[d], wy);
        chk("g_rnd_match", d, 64'(g_rnd[d] === wr), 1);
        err_next = 1'b0;
        if (slot_v[d][s]) begin
            id = slot_id[d][s];
            chk("a_ovld", d, a_ovld[d], !id);
            chk("b_ovld", d, b_ovld[d], id);
            chk("z_value", d, unmask(id ? b_z[d] : a_z[d]), slot_val[d][s]);
            chk("z_hold", d, unmask(id ? a_z[d] : b_z[d]), last_z[d][!id]);
            last_z[d][id] = slot_val[d][s];
            slot_v[d][s]  = 1'b0;
        end else begin
            chk("a_ovld_idle", d, a_ovld[d], 0);
            chk("b_ovld_idle", d, b_ovld[d], 0);
            chk("a_z_hold", d, unmask(a_z[d]), last_z[d][0]);
            chk("b_z_hold", d, unmask(b_z[d]), last_z[d][1]);
            if (g_ovld[d]) err_next = 1'b1;
        end
        if (gnt) begin
            t = (cyc + lat) % 16;
            slot_v[d][t]   = 1'b1;
            slot_id[d][t]  = w;
            slot_val[d][t] = unmask(wx) & unmask(wy);
            ptr[d]         = !w;
        end
        if (err_next) err_exp[d] = 1'b1;
        if (d == 0) begin
            model_grant = gnt;
            model_win   = w;
        end
    endtask

    task automatic new_data(input logic w);
        if (w) begin
            b_x = mask($urandom);
            b_y = mask($urandom);
        end else begin
            a_x = mask($urandom);
            a_y = mask($urandom);
        end
    endtask

    task automatic new_rnd();
        for (int i = 0; i < RANDNUM; i++) rnd_in[i*K_WIDTH +: K_WIDTH] = $urandom;
    endtask

    task automatic finish_cycle();
        model(0);
        model(1);
        @(posedge clk);
        #1;
        cyc++;
        if (model_grant) new_data(model_win);
        new_rnd();
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    typedef struct {
        logic a;
        logic b;
        logic r;
        logic ea;
        logic eb;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 1, 0};
        tbl[4]  = '{1, 1, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 1, 0};
        tbl[6]  = '{1, 1, 1, 0, 1};
        tbl[7]  = '{1, 1, 1, 1, 0};
        tbl[8]  = '{1, 1, 1, 0, 1};
        tbl[9]  = '{0, 1, 1, 0, 1};
        tbl[10] = '{1, 0, 1, 1, 0};
        tbl[11] = '{0, 0, 1, 0, 0};
        tbl[12] = '{1, 1, 1, 0, 1};
        tbl[13] = '{1, 1, 1, 1, 0};

        rst     = 1'b1;
        a_vld   = 1'b0;
        b_vld   = 1'b0;
        rnd_vld = 1'b0;
        spur[0] = 1'b0;
        spur[1] = 1'b0;
        new_data(1'b0);
        new_data(1'b1);
        new_rnd();
        tick();
        tick();
        rst = 1'b0;

        // Single A operation with known unmasked operands.
        a_x     = mask(32'hFFFF0000);
        a_y     = mask(32'h0F0F0F0F);
        a_vld   = 1'b1;
        rnd_vld = 1'b1;
        @(negedge clk);
        chk("t1_a_rdy", 0, a_rdy[0], 1);
        finish_cycle();
        a_vld = 1'b0;
        @(negedge clk);
        chk("t1_a_ovld", 0, a_ovld[0], 1);
        chk("t1_a_z", 0, unmask(a_z[0]), 32'h0F0F0000);
        chk("t1_b_ovld", 0, b_ovld[0], 0);
        finish_cycle();
        repeat (4) tick();

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Arbitration table: stalls on rnd_vld, RR alternation, lone requesters.
        for (int i = 0; i < 14; i++) begin
            a_vld   = tbl[i].a;
            b_vld   = tbl[i].b;
            rnd_vld = tbl[i].r;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("tbl_a_rdy", d, a_rdy[d], tbl[i].ea);
                chk("tbl_b_rdy", d, b_rdy[d], tbl[i].eb);
            end
            finish_cycle();
        end
        a_vld = 1'b0;
        b_vld = 1'b0;
        repeat (5) tick();

        // Spurious gadget result with an empty tag pipe on the LAT=3 DUT.
        spur[1] = 1'b1;
        tick();
        spur[1] = 1'b0;
        @(negedge clk);
        chk("spur_err", 1, err[1], 1);
        chk("spur_a_ovld", 1, a_ovld[1], 0);
        chk("spur_b_ovld", 1, b_ovld[1], 0);
        finish_cycle();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_clears_err", 1, err[1], 0);
        finish_cycle();

        // Reset while three operations are in flight.
        a_vld   = 1'b1;
        b_vld   = 1'b1;
        rnd_vld = 1'b1;
        repeat (3) tick();
        rst   = 1'b1;
        a_vld = 1'b0;
        b_vld = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("drop_a_ovld", 1, a_ovld[1], 0);
            chk("drop_b_ovld", 1, b_ovld[1], 0);
            chk("drop_err", 1, err[1], 0);
            finish_cycle();
        end
        a_vld = 1'b1;
        b_vld = 1'b1;
        @(negedge clk);
        chk("post_rst_fav_a", 1, a_rdy[1], 1);
        finish_cycle();
        a_vld = 1'b0;
        b_vld = 1'b0;

        // Randomized traffic; requesters hold vld/data until granted.
        for (int i = 0; i < 400; i++) begin
            if (!a_vld) a_vld = 1'($urandom_range(0, 1));
            if (!b_vld) b_vld = 1'($urandom_range(0, 1));
            rnd_vld = ($urandom_range(0, 3) != 0);
            tick();
            if (model_grant) begin
                if (model_win) b_vld = 1'($urandom_range(0, 1));
                else           a_vld = 1'($urandom_range(0, 1));
            end
        end
        a_vld   = 1'b0;
        b_vld   = 1'b0;
        rnd_vld = 1'b0;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secand_arb.md
Name: secand_arb

Overview:
- Round-robin arbiter and sequencer that shares one SecAND masked-AND gadget between two requesters, A and B.
- Issues one masked operand pair per cycle together with one fresh randomness word from the RNG, tracks in-flight operations in a LAT-deep tag pipeline, and routes each gadget result back to the requester that issued it.
- Sits between the B2A conversion stages and the shared gadget/RNG.

Parameters:
K_WIDTH, 32, bits per share
N_SHARES, 8, number of Boolean shares
LAT, 1, gadget latency in cycles from dvld to ovld; legal range 1..8
RANDNUM, N_SHARES*(N_SHARES-1), randomness words per operation (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
a_vld  in  1  requester A operand valid
a_rdy  out  1  requester A accepted this cycle
a_x  in  K_WIDTH*N_SHARES  A masked operand x
a_y  in  K_WIDTH*N_SHARES  A masked operand y
a_ovld  out  1  A result valid
a_z  out  K_WIDTH*N_SHARES  A masked result
b_vld, b_rdy, b_x, b_y, b_ovld, b_z  same as A, for requester B
rnd_vld  in  1  RNG word available
rnd_rdy  out  1  RNG word consumed this cycle
rnd_in  in  K_WIDTH*RANDNUM  fresh randomness
g_ena  out  1  gadget enable
g_dvld  out  1  gadget input valid
g_x, g_y  out  K_WIDTH*N_SHARES  gadget operands
g_rnd  out  K_WIDTH*RANDNUM  gadget randomness
g_z  in  K_WIDTH*N_SHARES  gadget result
g_ovld  in  1  gadget result valid
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge): all outputs go to 0. RR pointer is set to favour A, the tag pipeline is cleared, and err is cleared. The gadget is held in reset by the same reset (its rst_n = ~rst), so no stale g_ovld can appear after reset. A reset during an operation drops all in-flight operations without raising any response.
- g_ena: 1 in every cycle after reset is released.
- Issue condition: (a_vld|b_vld) & rnd_vld.
  - If only one requester is valid, it wins.
  - If both are valid, the RR favourite wins; after a grant the pointer flips to the other requester.
  - If rnd_vld=0, nothing is granted and the pointer is unchanged.
- Grant is combinational in the same cycle: winner's rdy=1, rnd_rdy=1, g_dvld=1, g_x/g_y = winner's operands, g_rnd = rnd_in. No grant means g_dvld=0 and g_x/g_y/g_rnd are driven to 0; masked data must not linger on the bus.
- Requesters hold vld and data stable until rdy. Operands are never modified by the arbiter.
- Tag pipeline: LAT-stage shift register of {valid, id}, with id 0=A and 1=B. A stage is written with {1,id} on grant and {0,x} otherwise.
- Response routing: when g_ovld=1 and tail.valid=1, the result goes to the requester named by tail.id: that requester's ovld=1 and z=g_z for exactly that cycle. The other requester's ovld=0 and its z holds its last value.
- Responses have no backpressure; requesters must accept on ovld.
- Throughput: one operation per cycle sustained. Results come back in issue order, exactly LAT cycles after grant.
- err is set, and stays set until reset, if either condition occurs:
  - g_ovld=1 while tail.valid=0; the result is dropped;
  - tail.valid=1 while g_ovld=0; no response is generated.
- Simultaneous grant and response in one cycle are legal and independent.

Decomposition:
- Package secand_pkg holds:
  - K_WIDTH, N_SHARES;
  - derived RANDNUM and MASKWIDTH;
  - typedef req_id_e {REQ_A, REQ_B};
  - typedef tag_t {logic vld; req_id_e id}.
- One sub-module, secand_tag_pipe, implements the LAT-deep tag shift register with head write and tail read.
- Arbiter, muxing and error logic stay in secand_arb.

Test Plan:
- Reset, then a_vld=1, rnd_vld=1, a_x shares XOR=0xFFFF0000, a_y XOR=0x0F0F0F0F -> a_rdy=1 in cycle 0; at LAT=1, a_ovld=1 one cycle later with XOR of a_z shares = 0x0F0F0000; b_ovld stays 0.
- a_vld=b_vld=1 held for 6 cycles, rnd_vld=1 -> grants alternate A,B,A,B,A,B; a_ovld and b_ovld alternate with the same pattern LAT cycles later; every unmasked z equals x&y.
- Both requesters valid, rnd_vld=0 for 3 cycles, then 1 -> no rdy, g_dvld=0, g_x/g_y/g_rnd all 0 for 3 cycles; then the RR favourite (A after reset) is granted first.
- Stub gadget with LAT=3 asserts a spurious g_ovld with the tag pipe empty -> err=1 next cycle and stays 1; no requester ovld is raised; rst clears err.
- Reset asserted while 3 operations are in flight (LAT=3) -> no a_ovld/b_ovld for the following 4 cycles, err=0, and the next grant favours A.
